// File: rtl/pc_npc_sequencer.sv
// PC/nPC sequencer for a delay-slot pipeline: sequential advance, delayed
// branches with annul, trap redirect and rejection of misaligned branch targets.
module pc_npc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_always,
    input  logic        br_annul,
    input  logic [31:0] br_target,
    input  logic        trap_valid,
    input  logic [31:0] trap_vector,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic        fetch_valid,
    output logic        slot_annul,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] npc_q;
    logic [31:0] npc_d;
    logic        fetch_valid_q;
    logic        fetch_valid_d;
    logic        slot_annul_q;
    logic        slot_annul_d;
    logic        align_err_q;
    logic        align_err_d;

    logic [31:0] trap_pc_s;
    logic [31:0] seq_npc_s;
    logic        misaligned_s;

    assign trap_pc_s    = {trap_vector[31:2], 2'b00};
    assign seq_npc_s    = npc_q + 32'd4;
    assign misaligned_s = (br_target[1:0] != 2'b00);

    assign pc          = pc_q;
    assign npc         = npc_q;
    assign fetch_valid = fetch_valid_q;
    assign slot_annul  = slot_annul_q;
    assign align_err   = align_err_q;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_INIT;
            pc_q          <= RESET_PC;
            npc_q         <= RESET_PC + 32'd4;
            fetch_valid_q <= 1'b0;
            slot_annul_q  <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            fetch_valid_q <= fetch_valid_d;
            slot_annul_q  <= slot_annul_d;
            align_err_q   <= align_err_d;
        end
    end

    // Next-state logic; a trap always pulls a held pipeline back into RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: state_d = S_RUN;
            S_RUN: begin
                if (stall && !trap_valid) begin
                    state_d = S_HOLD;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HOLD: begin
                if (!stall || trap_valid) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // PC/nPC update: trap beats freeze, freeze beats transfer, annulled slot ignores transfers
    always_comb begin
        pc_d          = pc_q;
        npc_d         = npc_q;
        slot_annul_d  = slot_annul_q;
        align_err_d   = 1'b0;
        fetch_valid_d = (state_d != S_INIT);
        case (state_q)
            S_RUN, S_HOLD: begin
                if (trap_valid) begin
                    pc_d         = trap_pc_s;
                    npc_d        = trap_pc_s + 32'd4;
                    slot_annul_d = 1'b0;
                end else if (stall || (state_q == S_HOLD)) begin
                    pc_d         = pc_q;
                    npc_d        = npc_q;
                    slot_annul_d = slot_annul_q;
                end else begin
                    pc_d         = npc_q;
                    npc_d        = seq_npc_s;
                    slot_annul_d = 1'b0;
                    if (br_valid && !slot_annul_q) begin
                        if (br_taken && misaligned_s) begin
                            align_err_d = 1'b1;
                        end else if (br_taken) begin
                            npc_d        = br_target;
                            slot_annul_d = br_annul && br_always;
                        end else begin
                            slot_annul_d = br_annul;
                        end
                    end else begin
                        align_err_d = 1'b0;
                    end
                end
            end
            default: begin
                pc_d         = RESET_PC;
                npc_d        = RESET_PC + 32'd4;
                slot_annul_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Self-checking bench for pc_npc_sequencer: directed scenarios plus random
// stimulus compared every cycle against a behavioural model of the PC rules.
module tb_pc_npc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_always;
    logic        br_annul;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        fetch_valid;
    logic        slot_annul;
    logic        align_err;

    int n_assert = 0;
    int n_fail   = 0;

    // model: phase 0 = first cycle after reset, 1 = issuing, 2 = held
    int          m_phase;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic        e_fv;
    logic        e_annul;
    logic        e_align;

    pc_npc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .br_always(br_always), .br_annul(br_annul),
        .br_target(br_target), .trap_valid(trap_valid), .trap_vector(trap_vector),
        .pc(pc), .npc(npc), .fetch_valid(fetch_valid), .slot_annul(slot_annul),
        .align_err(align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic        frozen;
        logic        accept;
        logic [31:0] t;
        if (!reset) begin
            e_pc = RST_PC; e_npc = RST_PC + 32'd4;
            e_fv = 1'b0; e_annul = 1'b0; e_align = 1'b0; m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1; e_fv = 1'b1; e_align = 1'b0;
        end else begin
            frozen  = (m_phase == 2) || stall;
            m_phase = (stall && !trap_valid) ? 2 : 1;
            e_align = 1'b0;
            if (trap_valid) begin
                t = trap_vector;
                t[1:0] = 2'b00;
                e_pc = t; e_npc = t + 32'd4; e_annul = 1'b0;
            end else if (!frozen) begin
                accept = br_valid && !e_annul;
                e_pc   = e_npc;
                if (accept && br_taken && (br_target % 4 != 0)) begin
                    e_align = 1'b1; e_npc = e_npc + 32'd4; e_annul = 1'b0;
                end else begin
                    e_npc   = (accept && br_taken) ? br_target : e_npc + 32'd4;
                    e_annul = accept && br_annul && (!br_taken || br_always);
                end
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".npc"}, npc, e_npc);
        chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, e_fv});
        chk({tag, ".annul"}, {31'd0, slot_annul}, {31'd0, e_annul});
        chk({tag, ".align"}, {31'd0, align_err}, {31'd0, e_align});
    endtask

    task automatic idle();
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
        br_always = 1'b0; br_annul = 1'b0; br_target = 32'd0;
        trap_valid = 1'b0; trap_vector = 32'd0;
    endtask

    // reset, with a trap offered during INIT that must be ignored, then run to pc=8
    task automatic reset_to_8(input string tag);
        idle();
        reset = 1'b0;
        step({tag, ".rst"});
        chk({tag, ".rst_fv"}, {31'd0, fetch_valid}, 32'd0);
        idle();
        trap_valid = 1'b1; trap_vector = 32'h0000_0500;
        step({tag, ".init"});
        chk({tag, ".init_pc"}, pc, RST_PC);
        idle();
        step({tag, ".r1"});
        step({tag, ".r2"});
        chk({tag, ".at8"}, pc, 32'h8);
    endtask

    initial begin
        idle();
        reset = 1'b0;
        step("d035.rst");
        chk("d035.pc0", pc, 32'h0); chk("d035.fv0", {31'd0, fetch_valid}, 32'd0);
        idle();
        step("d035.c1");
        chk("d035.pc1", pc, 32'h0); chk("d035.npc1", npc, 32'h4);
        chk("d035.fv1", {31'd0, fetch_valid}, 32'd1);
        step("d035.c2");
        chk("d035.pc2", pc, 32'h4); chk("d035.npc2", npc, 32'h8);
        step("d035.c3");
        chk("d035.pc3", pc, 32'h8); chk("d035.npc3", npc, 32'hC);

        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h100;
        step("d036.br");
        chk("d036.pc", pc, 32'hC); chk("d036.npc", npc, 32'h100);
        idle();
        step("d036.next");
        chk("d036.pc2", pc, 32'h100); chk("d036.npc2", npc, 32'h104);

        reset_to_8("d037");
        br_valid = 1'b1; br_taken = 1'b0; br_annul = 1'b1; br_target = 32'h300;
        step("d037.br");
        chk("d037.pc", pc, 32'hC); chk("d037.annul", {31'd0, slot_annul}, 32'd1);
        br_valid = 1'b1; br_taken = 1'b1; br_annul = 1'b0; br_target = 32'h400;
        step("d037.squash");
        chk("d037.pc2", pc, 32'h10); chk("d037.npc2", npc, 32'h14);
        chk("d037.annul2", {31'd0, slot_annul}, 32'd0);

        reset_to_8("d038");
        br_valid = 1'b1; br_taken = 1'b1; br_always = 1'b1; br_annul = 1'b1; br_target = 32'h200;
        step("d038.ba");
        chk("d038.pc", pc, 32'hC); chk("d038.annul", {31'd0, slot_annul}, 32'd1);
        idle();
        step("d038.next");
        chk("d038.pc2", pc, 32'h200); chk("d038.npc2", npc, 32'h204);

        idle(); stall = 1'b1;
        step("d039.s1");
        chk("d039.frozen", pc, 32'h200);
        trap_valid = 1'b1; trap_vector = 32'h803;
        step("d039.trap");
        chk("d039.tpc", pc, 32'h800); chk("d039.tnpc", npc, 32'h804);
        trap_valid = 1'b0;
        step("d039.s3");
        idle();
        step("d039.release");
        chk("d039.held", pc, 32'h800);
        step("d039.run");
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h102;
        step("d039.mis");
        chk("d039.align", {31'd0, align_err}, 32'd1); chk("d039.mnpc", npc, 32'h80C);
        idle();
        step("d039.after");
        chk("d039.align0", {31'd0, align_err}, 32'd0);

        trap_valid = 1'b1; trap_vector = 32'hFFFF_FFF8;
        step("d040.trap");
        idle();
        step("d040.c1");
        chk("d040.npcwrap", npc, 32'h0);
        step("d040.c2");
        chk("d040.pcwrap", pc, 32'h0);
        stall = 1'b1;
        step("d040.hold");
        reset = 1'b0; trap_valid = 1'b1; trap_vector = 32'h0000_0900;
        step("d040.rst");
        chk("d040.rpc", pc, RST_PC); chk("d040.rfv", {31'd0, fetch_valid}, 32'd0);

        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 99) >= 2);
            stall       = ($urandom_range(0, 99) < 20);
            br_valid    = ($urandom_range(0, 99) < 40);
            br_taken    = $urandom_range(0, 1) == 1;
            br_always   = $urandom_range(0, 3) == 0;
            br_annul    = $urandom_range(0, 1) == 1;
            br_target   = $urandom();
            if ($urandom_range(0, 3) != 0) br_target[1:0] = 2'b00;
            trap_valid  = ($urandom_range(0, 99) < 5);
            trap_vector = $urandom();
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
